// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM PIN checker.
package atm_pkg;

  typedef enum logic [2:0] {StIdle, StCmp, StGrant, StCopy, StLock} state_e;

  localparam int unsigned PIN_LEN            = 4;
  localparam int unsigned PIN_BASE_DEFAULT   = 0;
  localparam int unsigned ENTRY_BASE_DEFAULT = 4;

  // Register-file address of digit `off` in a 4-digit block starting at `base`.
  function automatic logic [3:0] rf_addr(input int unsigned base, input logic [2:0] off);
    return 4'(base + 32'(off));
  endfunction

endpackage

// File: rtl/atm_seq_counter.sv
// Step counter that sequences register-file addresses during compare and copy.
module atm_seq_counter (
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       start_i,
  input  logic       run_i,
  output logic [2:0] step_o
);

  logic [2:0] step_q, step_d;

  always_comb begin
    step_d = step_q;
    if (start_i) begin
      step_d = '0;
    end else if (run_i) begin
      step_d = step_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

  assign step_o = step_q;

endmodule

// File: rtl/atm_pin_checker.sv
// PIN entry, constant-time compare, lockout and PIN change against an external register file.
module atm_pin_checker
  import atm_pkg::*;
#(
  parameter int unsigned MAX_FAILS  = 3,
  parameter int unsigned PIN_BASE   = PIN_BASE_DEFAULT,
  parameter int unsigned ENTRY_BASE = ENTRY_BASE_DEFAULT
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       KEY_VALID,
  input  logic [3:0] KEY,
  input  logic       ENTER,
  input  logic       CANCEL,
  input  logic       CHG,
  input  logic       UNLOCK,
  output logic [3:0] RA,
  input  logic [3:0] DATA,
  output logic [3:0] WA,
  output logic [3:0] LD_DATA,
  output logic       WR,
  output logic       GRANTED,
  output logic       DENIED,
  output logic       LOCKED,
  output logic       BUSY,
  output logic [1:0] FAILS
);

  state_e                     state_q, state_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [1:0]                 fails_q, fails_d;
  logic [3:0]                 ra_q, ra_d, wa_q, wa_d, ld_q, ld_d;
  logic                       wr_q, wr_d, granted_q, granted_d, denied_q, denied_d;
  logic                       locked_q, locked_d, busy_q, busy_d;
  logic [3:0]                 pin_dig_q, pin_dig_d;
  logic                       mis_q, mis_d;
  // Copy of the entered digits so COPY can present LD_DATA in the same cycle as RA.
  logic [PIN_LEN-1:0][3:0]    shadow_q, shadow_d;

  logic       seq_start, seq_run, fail;
  logic [2:0] step, nstep;
  logic [1:0] cnext;
  logic       key_ok, full;

  atm_seq_counter u_seq (
    .clk_i  (CLK),
    .clr_i  (CLR),
    .start_i(seq_start),
    .run_i  (seq_run),
    .step_o (step)
  );

  assign key_ok = KEY_VALID && (KEY <= 4'd9) && (cnt_q < 3'(PIN_LEN));
  assign full   = (cnt_q == 3'(PIN_LEN));
  assign nstep  = step + 3'd1;
  assign cnext  = step[1:0] + 2'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fails_d   = fails_q;
    ra_d      = ra_q;
    wa_d      = wa_q;
    ld_d      = ld_q;
    wr_d      = 1'b0;
    granted_d = granted_q;
    denied_d  = 1'b0;
    locked_d  = locked_q;
    busy_d    = busy_q;
    pin_dig_d = pin_dig_q;
    mis_d     = mis_q;
    shadow_d  = shadow_q;
    seq_start = 1'b0;
    seq_run   = 1'b0;
    fail      = 1'b0;

    unique case (state_q)
      StIdle, StGrant: begin
        if (CANCEL) begin
          cnt_d     = '0;
          state_d   = StIdle;
          granted_d = 1'b0;
        end else if (ENTER) begin
          if (state_q == StIdle) begin
            if (full) begin
              state_d   = StCmp;
              seq_start = 1'b1;
              busy_d    = 1'b1;
              mis_d     = 1'b0;
              ra_d      = rf_addr(PIN_BASE, 3'd0);
            end else begin
              fail = 1'b1;
            end
          end else if (CHG && full) begin
            state_d   = StCopy;
            seq_start = 1'b1;
            busy_d    = 1'b1;
            ra_d      = rf_addr(ENTRY_BASE, 3'd0);
            wa_d      = rf_addr(PIN_BASE, 3'd0);
            ld_d      = shadow_q[0];
            wr_d      = 1'b1;
          end
        end else if (key_ok) begin
          wr_d                   = 1'b1;
          wa_d                   = rf_addr(ENTRY_BASE, cnt_q);
          ld_d                   = KEY;
          shadow_d[cnt_q[1:0]]   = KEY;
          cnt_d                  = cnt_q + 3'd1;
        end
      end

      StCmp: begin
        seq_run = 1'b1;
        // Even steps read a stored digit, odd steps compare the matching entered digit.
        if (!step[0]) begin
          pin_dig_d = DATA;
        end else begin
          mis_d = mis_q | (DATA != pin_dig_q);
        end
        if (step != 3'd7) begin
          ra_d = rf_addr(nstep[0] ? ENTRY_BASE : PIN_BASE, {1'b0, nstep[2:1]});
        end else begin
          busy_d = 1'b0;
          cnt_d  = '0;
          if (mis_d) begin
            fail = 1'b1;
          end else begin
            state_d   = StGrant;
            granted_d = 1'b1;
            fails_d   = '0;
          end
        end
      end

      StCopy: begin
        seq_run = 1'b1;
        if (step[1:0] != 2'd3) begin
          ra_d = rf_addr(ENTRY_BASE, {1'b0, cnext});
          wa_d = rf_addr(PIN_BASE, {1'b0, cnext});
          ld_d = shadow_q[cnext];
          wr_d = 1'b1;
        end else begin
          state_d = StGrant;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end

      StLock: begin
        if (UNLOCK) begin
          state_d  = StIdle;
          fails_d  = '0;
          locked_d = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase

    if (fail) begin
      denied_d = 1'b1;
      fails_d  = fails_q + 2'd1;
      cnt_d    = '0;
      if (32'(fails_q) + 32'd1 == MAX_FAILS) begin
        state_d  = StLock;
        locked_d = 1'b1;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      fails_q   <= '0;
      ra_q      <= '0;
      wa_q      <= '0;
      ld_q      <= '0;
      wr_q      <= 1'b0;
      granted_q <= 1'b0;
      denied_q  <= 1'b0;
      locked_q  <= 1'b0;
      busy_q    <= 1'b0;
      pin_dig_q <= '0;
      mis_q     <= 1'b0;
      shadow_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fails_q   <= fails_d;
      ra_q      <= ra_d;
      wa_q      <= wa_d;
      ld_q      <= ld_d;
      wr_q      <= wr_d;
      granted_q <= granted_d;
      denied_q  <= denied_d;
      locked_q  <= locked_d;
      busy_q    <= busy_d;
      pin_dig_q <= pin_dig_d;
      mis_q     <= mis_d;
      shadow_q  <= shadow_d;
    end
  end

  assign RA      = ra_q;
  assign WA      = wa_q;
  assign LD_DATA = ld_q;
  assign WR      = wr_q;
  assign GRANTED = granted_q;
  assign DENIED  = denied_q;
  assign LOCKED  = locked_q;
  assign BUSY    = busy_q;
  assign FAILS   = fails_q;

endmodule

// File: tb/tb_atm_pin_checker.sv
// Randomized self-checking bench for atm_pin_checker with a behavioural 16x4 register file.
module tb_atm_pin_checker;

  logic       CLK = 1'b0;
  logic       CLR, KEY_VALID, ENTER, CANCEL, CHG, UNLOCK;
  logic [3:0] KEY, RA, DATA, WA, LD_DATA;
  logic       WR, GRANTED, DENIED, LOCKED, BUSY;
  logic [1:0] FAILS;

  logic [3:0] rf [16];
  logic       tb_ld;
  logic [3:0] tb_la, tb_ldd;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: stored PIN as four digits, attempt counter, status.
  logic [15:0] m_pin;
  int          m_fails;
  bit          m_granted, m_locked;
  int          keyq[$];

  localparam int MaxFails = 3;

  atm_pin_checker dut (
    .CLK(CLK), .CLR(CLR), .KEY_VALID(KEY_VALID), .KEY(KEY), .ENTER(ENTER), .CANCEL(CANCEL),
    .CHG(CHG), .UNLOCK(UNLOCK), .RA(RA), .DATA(DATA), .WA(WA), .LD_DATA(LD_DATA), .WR(WR),
    .GRANTED(GRANTED), .DENIED(DENIED), .LOCKED(LOCKED), .BUSY(BUSY), .FAILS(FAILS)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (tb_ld) rf[tb_la] <= tb_ldd;
    else if (WR) rf[WA] <= LD_DATA;
  end
  assign DATA = rf[RA];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_rf(input int addr, input logic [3:0] d);
    tb_ld = 1'b1; tb_la = 4'(addr); tb_ldd = d;
    tick();
    tb_ld = 1'b0;
  endtask

  task automatic load_pin();
    for (int i = 0; i < 4; i++) load_rf(i, m_pin[i*4 +: 4]);
  endtask

  task automatic do_clr();
    CLR = 1'b1; tick(); CLR = 1'b0;
    m_fails = 0; m_granted = 0; m_locked = 0;
  endtask

  task automatic do_cancel();
    CANCEL = 1'b1; tick(); CANCEL = 1'b0;
    m_granted = 0;
    n_checks++; if (GRANTED !== 1'b0) $display("FAIL cancel_granted got %b want 0", GRANTED);
    else n_pass++;
  endtask

  // Enters keyq from IDLE then ENTER; expectations come from plain digit comparison.
  task automatic run_attempt(input string tag);
    int          cnt = 0, bad = 0, busy_n = 0, ra_bad = 0;
    logic [15:0] ent = '0;
    bit          match;
    foreach (keyq[i]) begin
      KEY_VALID = 1'b1; KEY = 4'(keyq[i]); tick(); KEY_VALID = 1'b0;
      if (keyq[i] <= 9 && cnt < 4) begin
        if (WR !== 1'b1 || WA !== 4'(4 + cnt) || LD_DATA !== 4'(keyq[i])) bad++;
        ent[cnt*4 +: 4] = 4'(keyq[i]);
        cnt++;
      end else if (WR !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL %s key_writes got %0d bad want 0", tag, bad);
    else n_pass++;
    ENTER = 1'b1; tick(); ENTER = 1'b0;
    if (cnt == 4) begin
      while (BUSY === 1'b1 && busy_n < 20) begin
        if (RA !== 4'((busy_n % 2 == 1) ? 4 + busy_n / 2 : busy_n / 2)) ra_bad++;
        busy_n++;
        tick();
      end
      n_checks++;
      if (busy_n != 8 || ra_bad != 0)
        $display("FAIL %s cmp_busy got %0d cycles %0d bad RA want 8 cycles 0 bad", tag, busy_n,
                 ra_bad);
      else n_pass++;
      match = (ent == m_pin);
    end else begin
      match = 0;
    end
    if (match) begin
      m_granted = 1; m_fails = 0;
    end else begin
      m_fails++;
      if (m_fails == MaxFails) m_locked = 1;
    end
    n_checks++;
    if (GRANTED !== m_granted || DENIED !== !match || FAILS !== 2'(m_fails) ||
        LOCKED !== m_locked)
      $display("FAIL %s result got G%b D%b F%0d L%b want G%b D%b F%0d L%b", tag, GRANTED, DENIED,
               FAILS, LOCKED, m_granted, !match, m_fails, m_locked);
    else n_pass++;
    if (!match) begin
      tick();
      n_checks++; if (DENIED !== 1'b0) $display("FAIL %s denied_pulse got %b want 0", tag, DENIED);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    CLR = 1'b1; tick(); tick(); CLR = 1'b0;
    for (int i = 0; i < 16; i++) load_rf(i, 4'd0);
    m_pin = '0; m_fails = 0; m_granted = 0; m_locked = 0;
    n_checks++;
    if ({RA, WA, LD_DATA, WR, GRANTED, DENIED, LOCKED, BUSY, FAILS} !== 21'd0)
      $display("FAIL reset_outputs got %h want 0",
               {RA, WA, LD_DATA, WR, GRANTED, DENIED, LOCKED, BUSY, FAILS});
    else n_pass++;
  endtask

  task automatic test_default_grant();
    keyq = '{0, 0, 0, 0};
    run_attempt("grant0000");
    do_cancel();
  endtask

  task automatic test_lockout();
    do_clr();
    keyq = '{1, 2, 3, 4};
    for (int i = 0; i < 3; i++) run_attempt("lockout");
    KEY_VALID = 1'b1; KEY = 4'd5; tick(); KEY_VALID = 1'b0;
    n_checks++; if (WR !== 1'b0) $display("FAIL locked_key_wr got %b want 0", WR);
    else n_pass++;
    ENTER = 1'b1; CANCEL = 1'b1; tick(); ENTER = 1'b0; CANCEL = 1'b0;
    n_checks++; if (LOCKED !== 1'b1) $display("FAIL locked_hold got %b want 1", LOCKED);
    else n_pass++;
    UNLOCK = 1'b1; tick(); UNLOCK = 1'b0;
    m_locked = 0; m_fails = 0;
    n_checks++;
    if (LOCKED !== 1'b0 || FAILS !== 2'd0)
      $display("FAIL unlock got L%b F%0d want L0 F0", LOCKED, FAILS);
    else n_pass++;
  endtask

  task automatic test_pin_change();
    int newpin[4] = '{5, 9, 2, 7};
    int bad = 0;
    keyq = '{0, 0, 0, 0};
    run_attempt("pre_change");
    CHG = 1'b1;
    foreach (newpin[i]) begin
      KEY_VALID = 1'b1; KEY = 4'(newpin[i]); tick(); KEY_VALID = 1'b0;
      if (WR !== 1'b1 || WA !== 4'(4 + i) || LD_DATA !== 4'(newpin[i])) bad++;
    end
    ENTER = 1'b1; tick(); ENTER = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (WR !== 1'b1 || WA !== 4'(k) || LD_DATA !== 4'(newpin[k]) || RA !== 4'(4 + k) ||
          BUSY !== 1'b1) bad++;
      tick();
    end
    CHG = 1'b0;
    n_checks++; if (bad != 0) $display("FAIL copy_seq got %0d bad cycles want 0", bad);
    else n_pass++;
    n_checks++;
    if (BUSY !== 1'b0 || WR !== 1'b0 || GRANTED !== 1'b1)
      $display("FAIL copy_end got B%b W%b G%b want B0 W0 G1", BUSY, WR, GRANTED);
    else n_pass++;
    for (int i = 0; i < 4; i++) m_pin[i*4 +: 4] = 4'(newpin[i]);
    do_cancel();
    keyq = '{5, 9, 2, 7};
    run_attempt("new_pin");
    do_cancel();
  endtask

  task automatic test_invalid_key();
    int bad = 0;
    keyq = '{3, 12, 4};
    run_attempt("bad_key");
    keyq = '{1, 2, 3, 4};
    foreach (keyq[i]) begin
      KEY_VALID = 1'b1; KEY = 4'(keyq[i]); tick(); KEY_VALID = 1'b0;
    end
    KEY_VALID = 1'b1; KEY = 4'd5; tick(); KEY_VALID = 1'b0;
    n_checks++; if (WR !== 1'b0) $display("FAIL fifth_digit_wr got %b want 0", WR);
    else n_pass++;
    do_cancel();
  endtask

  task automatic test_clr_mid_cmp();
    keyq = '{0, 0, 0, 0};
    foreach (keyq[i]) begin
      KEY_VALID = 1'b1; KEY = 4'(keyq[i]); tick(); KEY_VALID = 1'b0;
    end
    ENTER = 1'b1; tick(); ENTER = 1'b0;
    tick(); tick(); tick();
    do_clr();
    n_checks++;
    if (BUSY !== 1'b0 || WR !== 1'b0 || FAILS !== 2'd0 || GRANTED !== 1'b0)
      $display("FAIL clr_mid_cmp got B%b W%b F%0d G%b want all 0", BUSY, WR, FAILS, GRANTED);
    else n_pass++;
    KEY_VALID = 1'b1; KEY = 4'd8; tick(); KEY_VALID = 1'b0;
    n_checks++;
    if (WR !== 1'b1 || WA !== 4'd4) $display("FAIL clr_idle_key got W%b A%0d want W1 A4", WR, WA);
    else n_pass++;
    do_cancel();
  endtask

  task automatic test_cancel_priority();
    int bad = 0;
    KEY_VALID = 1'b1; KEY = 4'd1; tick(); tick();
    KEY = 4'd7; CANCEL = 1'b1; tick(); KEY_VALID = 1'b0; CANCEL = 1'b0;
    n_checks++; if (WR !== 1'b0) $display("FAIL cancel_prio_wr got %b want 0", WR);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      KEY_VALID = 1'b1; KEY = 4'(i + 3); tick(); KEY_VALID = 1'b0;
      if (WR !== 1'b1 || WA !== 4'(4 + i)) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL cancel_then_keys got %0d bad want 0", bad);
    else n_pass++;
    do_cancel();
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      if (m_locked) begin
        UNLOCK = 1'b1; tick(); UNLOCK = 1'b0;
        m_locked = 0; m_fails = 0;
        n_checks++;
        if (LOCKED !== 1'b0 || FAILS !== 2'd0)
          $display("FAIL rnd_unlock got L%b F%0d want L0 F0", LOCKED, FAILS);
        else n_pass++;
      end
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < 4; i++) m_pin[i*4 +: 4] = 4'($urandom_range(0, 9));
        load_pin();
      end
      keyq.delete();
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 4; i++) keyq.push_back(int'(m_pin[i*4 +: 4]));
      end else begin
        int n = $urandom_range(2, 6);
        for (int i = 0; i < n; i++) keyq.push_back($urandom_range(0, 12));
      end
      run_attempt("random");
      if (m_granted) do_cancel();
    end
  endtask

  initial begin
    CLR = 1'b0; KEY_VALID = 1'b0; KEY = '0; ENTER = 1'b0; CANCEL = 1'b0; CHG = 1'b0;
    UNLOCK = 1'b0; tb_ld = 1'b0; tb_la = '0; tb_ldd = '0;
    test_reset();
    test_default_grant();
    test_lockout();
    test_pin_change();
    test_invalid_key();
    test_clr_mid_cmp();
    test_cancel_priority();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
